wash_sequencer: RTL and testbench
=================================

WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 SHALL have parameter FILL_T, default 8'd10, FILL phase duration in seconds (1..255).
REQ-002 SHALL have parameter WASH_T, default 8'd60, WASH phase duration in seconds (1..255).
REQ-003 SHALL have parameter RINSE_T, default 8'd30, RINSE phase duration in seconds (1..255).
REQ-004 SHALL have parameter SPIN_T, default 8'd20, SPIN phase duration in seconds (1..255).
REQ-005 SHALL have parameter DIR_T, default 8'd5, seconds between motor direction reversals in WASH/RINSE (1..255).
REQ-006 SHALL have parameter BUZZ_T, default 8'd3, DONE buzzer duration in seconds (1..255).
REQ-007 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port clk_1hz  input  1  1 Hz square wave from the frequency divider, asynchronous to clk.
REQ-010 SHALL have port start  input  1  single-cycle start request.
REQ-011 SHALL have port mode  input  2  program select, sampled only when start is accepted.
REQ-012 SHALL have port pause  input  1  level; while high, the countdown is frozen and actuators are off.
REQ-013 SHALL have port abort  input  1  single-cycle request to return to IDLE.
REQ-014 SHALL have port phase  output  3  IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5.
REQ-015 SHALL have port remain  output  8  seconds left in the current phase, unsigned binary.
REQ-016 SHALL have ports motor_fwd, motor_rev, water_in, drain, buzzer  output  1 each  actuator enables.
REQ-017 SHALL have port done  output  1  one-cycle pulse on entry to DONE.
REQ-018 SHALL have port busy  output  1  high whenever phase is not IDLE.

Function
REQ-019 SHALL sync clk_1hz through two flops, then feed a third flop; tick = sync2 & ~sync3, so each rising edge of clk_1hz yields exactly one internal tick.
REQ-020 SHALL act on a tick at the clk edge at which tick is high, which is 3 clk edges after clk_1hz is first sampled high.
REQ-021 SHALL accept start only in IDLE, latching mode at acceptance; start is ignored in all other phases.
REQ-022 SHALL sequence phases by latched mode as follows: mode 0 = FILL, WASH, RINSE, SPIN, DONE; mode 1 = FILL, WASH, SPIN, DONE; mode 2 = SPIN, DONE; mode 3 = FILL, RINSE, SPIN, DONE.
REQ-023 SHALL, on entry to any phase, load remain with that phase's duration (DONE loads BUZZ_T), in the same cycle the phase changes.
REQ-024 SHALL, on a tick with pause low: if remain > 1, decrement remain by 1; if remain == 1, advance to the next phase and load its duration.
REQ-025 SHALL advance DONE to IDLE on the tick that sees remain == 1.
REQ-026 SHALL hold remain at 0 in IDLE.
REQ-027 SHALL never let remain wrap below 1 in an active phase.
REQ-028 SHALL discard ticks while pause is high (not queued), leaving phase and remain unchanged.
REQ-029 SHALL drive actuators combinationally from the registered phase and direction bit, all gated low while pause is high:
  - FILL: water_in=1
  - WASH and RINSE: motor_fwd=dir, motor_rev=~dir
  - SPIN: motor_fwd=1, drain=1
  - DONE: buzzer=1
  - IDLE: all low
REQ-030 SHALL clear dir to 1 and a seconds sub-counter to 0 on entry to WASH or RINSE.
REQ-031 SHALL, on each unpaused tick in WASH or RINSE, increment the sub-counter; when it reaches DIR_T, the sub-counter resets to 0 and dir toggles.
REQ-032 SHALL never assert motor_fwd and motor_rev together.
REQ-033 SHALL make done a registered pulse high for exactly the first cycle phase==DONE.
REQ-034 SHALL give abort priority over start, tick and pause when asserted: next cycle phase=IDLE, remain=0, all actuators low, no done pulse.
REQ-035 SHALL, when start and abort coincide in IDLE, remain in IDLE.

Reset
REQ-036 SHALL, while rst is low, immediately force: phase=IDLE, remain=0, dir=1, sub-counter=0, latched mode=0, sync flops=0, done=0, busy=0, all actuators low.
REQ-037 SHALL produce no spurious tick in the first cycles after rst deasserts, because the sync flops clear to 0.
REQ-038 SHALL, if rst is asserted mid-cycle of the program, abandon it with no done pulse.

Verification (FILL_T=2, WASH_T=4, RINSE_T=3, SPIN_T=2, DIR_T=2, BUZZ_T=1; clk_1hz driven at 1 period per 20 clk)
REQ-039 SHALL check: start with mode=0 -> phases FILL(2 ticks), WASH(4), RINSE(3), SPIN(2), DONE(1), IDLE; done high 1 cycle; 12 ticks in total.
REQ-040 SHALL check: WASH with DIR_T=2 -> motor_fwd for ticks 1-2, motor_rev for ticks 3-4, never both high.
REQ-041 SHALL check: mode=2 -> SPIN (remain 2, then 1), DONE, IDLE; water_in never asserted.
REQ-042 SHALL check: pause high across 3 ticks in WASH with remain=3 -> remain stays 3 and actuators stay 0; after release the next tick gives remain=2.
REQ-043 SHALL check: abort in RINSE coinciding with a tick -> IDLE next cycle, remain=0, done never asserted; start during SPIN is ignored.
REQ-044 SHALL check: rst pulsed low mid-WASH -> all outputs are at reset values without waiting for a clk edge; a subsequent start runs normally.

Source files
------------

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: steps through FILL/WASH/RINSE/SPIN/DONE on
// 1 Hz ticks derived from an asynchronous clk_1hz, driving the actuator enables.
module wash_sequencer #(
    parameter logic [7:0] FILL_T  = 8'd10,
    parameter logic [7:0] WASH_T  = 8'd60,
    parameter logic [7:0] RINSE_T = 8'd30,
    parameter logic [7:0] SPIN_T  = 8'd20,
    parameter logic [7:0] DIR_T   = 8'd5,
    parameter logic [7:0] BUZZ_T  = 8'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1hz,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       pause,
    input  logic       abort,
    output logic [2:0] phase,
    output logic [7:0] remain,
    output logic       motor_fwd,
    output logic       motor_rev,
    output logic       water_in,
    output logic       drain,
    output logic       buzzer,
    output logic       done,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4,
        DONE  = 3'd5
    } phase_t;

    phase_t     phase_q, phase_d, nxt_phase;
    logic [7:0] remain_q, remain_d;
    logic [7:0] sub_q, sub_d;
    logic       dir_q, dir_d;
    logic [1:0] mode_q, mode_d;
    logic       done_q, done_d;
    logic [2:0] sync_q, sync_d;
    logic       tick;

    function automatic phase_t next_phase(input logic [1:0] m, input phase_t p);
        case (p)
            FILL:    next_phase = (m == 2'd3) ? RINSE : WASH;
            WASH:    next_phase = (m == 2'd1) ? SPIN : RINSE;
            RINSE:   next_phase = SPIN;
            SPIN:    next_phase = DONE;
            default: next_phase = IDLE;
        endcase
    endfunction

    function automatic logic [7:0] phase_dur(input phase_t p);
        case (p)
            FILL:    phase_dur = FILL_T;
            WASH:    phase_dur = WASH_T;
            RINSE:   phase_dur = RINSE_T;
            SPIN:    phase_dur = SPIN_T;
            DONE:    phase_dur = BUZZ_T;
            default: phase_dur = 8'd0;
        endcase
    endfunction

    // Two-flop synchroniser plus an edge-detect flop: one tick per clk_1hz rise.
    assign sync_d = {sync_q[1:0], clk_1hz};
    assign tick   = sync_q[1] & ~sync_q[2];

    always_comb begin
        phase_d   = phase_q;
        remain_d  = remain_q;
        sub_d     = sub_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        nxt_phase = next_phase(mode_q, phase_q);
        if (abort) begin
            phase_d  = IDLE;
            remain_d = 8'd0;
            sub_d    = 8'd0;
            dir_d    = 1'b1;
        end else if (phase_q == IDLE) begin
            remain_d = 8'd0;
            if (start) begin
                mode_d   = mode;
                phase_d  = (mode == 2'd2) ? SPIN : FILL;
                remain_d = phase_dur(phase_d);
                sub_d    = 8'd0;
                dir_d    = 1'b1;
            end
        end else if (tick && !pause) begin
            if (phase_q == WASH || phase_q == RINSE) begin
                if (sub_q + 8'd1 == DIR_T) begin
                    sub_d = 8'd0;
                    dir_d = ~dir_q;
                end else begin
                    sub_d = sub_q + 8'd1;
                end
            end
            if (remain_q > 8'd1) begin
                remain_d = remain_q - 8'd1;
            end else begin
                // Last second of this phase: the successor loads its full duration.
                phase_d  = nxt_phase;
                remain_d = phase_dur(nxt_phase);
                done_d   = (nxt_phase == DONE);
                if (nxt_phase == WASH || nxt_phase == RINSE) begin
                    sub_d = 8'd0;
                    dir_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= IDLE;
            remain_q <= 8'd0;
            sub_q    <= 8'd0;
            dir_q    <= 1'b1;
            mode_q   <= 2'd0;
            done_q   <= 1'b0;
            sync_q   <= 3'b000;
        end else begin
            phase_q  <= phase_d;
            remain_q <= remain_d;
            sub_q    <= sub_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            sync_q   <= sync_d;
        end
    end

    // Actuators follow the registered phase; pause silences everything.
    always_comb begin
        motor_fwd = 1'b0;
        motor_rev = 1'b0;
        water_in  = 1'b0;
        drain     = 1'b0;
        buzzer    = 1'b0;
        if (!pause) begin
            case (phase_q)
                FILL:  water_in = 1'b1;
                WASH, RINSE: begin
                    motor_fwd = dir_q;
                    motor_rev = ~dir_q;
                end
                SPIN: begin
                    motor_fwd = 1'b1;
                    drain     = 1'b1;
                end
                DONE:  buzzer = 1'b1;
                default: ;
            endcase
        end
    end

    assign phase  = phase_q;
    assign remain = remain_q;
    assign done   = done_q;
    assign busy   = (phase_q != IDLE);
endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer with short phase durations; one tick per
// 20 clk cycles of clk_1hz, outputs sampled on the falling clk edge.
module tb_wash_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_1hz = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] phase;
    logic [7:0] remain;
    logic       motor_fwd, motor_rev, water_in, drain, buzzer, done, busy;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int done_bad = 0;
    int both_cnt = 0;
    int water_cnt = 0;
    int d0, w0;

    int exp_ph [12] = '{1, 2, 2, 2, 2, 3, 3, 3, 4, 4, 5, 0};
    int exp_rm [12] = '{1, 4, 3, 2, 1, 3, 2, 1, 2, 1, 1, 0};

    wash_sequencer #(
        .FILL_T(8'd2), .WASH_T(8'd4), .RINSE_T(8'd3),
        .SPIN_T(8'd2), .DIR_T(8'd2), .BUZZ_T(8'd1)
    ) dut (
        .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .start(start), .mode(mode),
        .pause(pause), .abort(abort), .phase(phase), .remain(remain),
        .motor_fwd(motor_fwd), .motor_rev(motor_rev), .water_in(water_in),
        .drain(drain), .buzzer(buzzer), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (done && phase != 3'd5) done_bad++;
        if (motor_fwd && motor_rev) both_cnt++;
        if (water_in) water_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    task automatic do_tick();
        @(negedge clk) clk_1hz = 1'b1;
        repeat (10) @(negedge clk);
        clk_1hz = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk) begin start = 1'b1; mode = m; end
        @(negedge clk) start = 1'b0;
    endtask

    task automatic act_vec(input string tag, input logic [4:0] exp_v);
        check(tag, {motor_fwd, motor_rev, water_in, drain, buzzer}, exp_v);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_phase", phase, 0);
        check("rst_remain", remain, 0);
        check("rst_busy_done", {busy, done}, 0);
        act_vec("rst_act", 5'b00000);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("no_spurious_tick", {phase, remain}, 0);

        // Full program, mode 0.
        pulse_start(2'd0);
        check("m0_fill_phase", phase, 1);
        check("m0_fill_remain", remain, 2);
        act_vec("m0_fill_act", 5'b00100);
        check("m0_busy", busy, 1);
        for (int k = 0; k < 12; k++) begin
            do_tick();
            check($sformatf("m0_t%0d_phase", k + 1), phase, exp_ph[k]);
            check($sformatf("m0_t%0d_remain", k + 1), remain, exp_rm[k]);
            if (k >= 1 && k <= 4)
                check($sformatf("m0_t%0d_dir", k + 1), {motor_fwd, motor_rev}, (k <= 2) ? 2'b10 : 2'b01);
            if (k == 5) act_vec("m0_rinse_act", 5'b10000);
            if (k == 8) act_vec("m0_spin_act", 5'b10010);
            if (k == 10) act_vec("m0_done_act", 5'b00001);
            if (k == 10) check("m0_done_seen", done_cnt, 1);
        end
        check("m0_done_once", done_cnt, 1);
        check("m0_idle_busy", busy, 0);

        // Spin-only program, mode 2.
        w0 = water_cnt;
        pulse_start(2'd2);
        check("m2_phase", phase, 4);
        check("m2_remain", remain, 2);
        do_tick();
        check("m2_t1_remain", remain, 1);
        do_tick();
        check("m2_t2_phase", phase, 5);
        do_tick();
        check("m2_t3_idle", {phase, remain}, 0);
        check("m2_no_water", water_cnt - w0, 0);
        check("m2_done_cnt", done_cnt, 2);

        // Pause in WASH, mode 1.
        pulse_start(2'd1);
        do_tick();
        do_tick();
        check("pz_wash_phase", phase, 2);
        do_tick();
        check("pz_remain3", remain, 3);
        @(negedge clk) pause = 1'b1;
        @(negedge clk);
        act_vec("pz_act_off", 5'b00000);
        do_tick();
        do_tick();
        do_tick();
        check("pz_frozen_remain", remain, 3);
        check("pz_frozen_phase", phase, 2);
        act_vec("pz_frozen_act", 5'b00000);
        @(negedge clk) pause = 1'b0;
        do_tick();
        check("pz_resume_remain", remain, 2);
        act_vec("pz_resume_rev", 5'b01000);
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("pz_abort_idle", {phase, remain}, 0);

        // Abort in RINSE on the same edge as a tick, mode 3.
        d0 = done_cnt;
        pulse_start(2'd3);
        do_tick();
        do_tick();
        check("ab_rinse_phase", phase, 3);
        check("ab_rinse_remain", remain, 3);
        @(negedge clk) clk_1hz = 1'b1;
        @(negedge clk);
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("ab_idle", {phase, remain}, 0);
        act_vec("ab_act", 5'b00000);
        repeat (8) @(negedge clk);
        clk_1hz = 1'b0;
        repeat (10) @(negedge clk);
        check("ab_no_done", done_cnt - d0, 0);

        // Start ignored while SPIN is running; start+abort in IDLE stays IDLE.
        pulse_start(2'd2);
        pulse_start(2'd0);
        check("ign_phase", phase, 4);
        check("ign_remain", remain, 2);
        do_tick();
        do_tick();
        check("ign_done_phase", phase, 5);
        do_tick();
        check("ign_idle", phase, 0);
        @(negedge clk) begin start = 1'b1; abort = 1'b1; mode = 2'd0; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        check("sa_idle", {phase, busy}, 0);

        // Asynchronous reset mid-WASH.
        d0 = done_cnt;
        pulse_start(2'd0);
        do_tick();
        do_tick();
        do_tick();
        check("rs_wash_remain", remain, 3);
        #2 rst = 1'b0;
        #1;
        check("rs_async_state", {phase, remain, busy, done}, 0);
        act_vec("rs_async_act", 5'b00000);
        @(negedge clk) rst = 1'b1;
        pulse_start(2'd2);
        check("rs_restart", {phase, remain}, {3'd4, 8'd2});
        do_tick();
        do_tick();
        do_tick();
        check("rs_final_idle", phase, 0);
        check("rs_done_once", done_cnt - d0, 1);

        check("never_both_motors", both_cnt, 0);
        check("done_only_in_done", done_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
